// File: rtl/pc_gen_if.sv
// Fetch-PC control bundle: redirect requests from the pipeline in, the
// fetch PC and return-stack status out.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            trap_i;
  logic            br_taken_i;
  logic [XLEN-1:0] br_target_i;
  logic            jmp_i;
  logic [XLEN-1:0] jmp_target_i;
  logic            call_i;
  logic            ret_i;
  logic [XLEN-1:0] ret_target_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] npc_o;
  logic            pc_valid_o;
  logic            redirect_o;
  logic            misalign_o;
  logic            ras_empty_o;
  logic            ras_full_o;

  modport master (
    output stall_i, trap_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
           call_i, ret_i, ret_target_i,
    input  pc_o, npc_o, pc_valid_o, redirect_o, misalign_o,
           ras_empty_o, ras_full_o
  );

  modport slave (
    input  stall_i, trap_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
           call_i, ret_i, ret_target_i,
    output pc_o, npc_o, pc_valid_o, redirect_o, misalign_o,
           ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program counter: picks the next PC from trap/branch/jump/return/stall/
// sequential sources and keeps a small circular return-address stack.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(4),
  parameter int              INST_BYTES = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int              PW       = $clog2(RAS_DEPTH);
  localparam int              CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = STEP - XLEN'(1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, npc;
  logic            valid_q;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic            tgt_chk;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty_q, full_q;
  logic            ras_en, wr_en;
  logic [XLEN-1:0] ret_addr, ras_top;

  assign ras_top  = ras_q[ptr_q];
  assign ret_addr = pc_q + STEP;

  // The PC loaded by reset has not been fetched yet, so the first
  // sequential step after reset holds it rather than advancing.
  always_comb begin
    npc        = valid_q ? pc_q + STEP : pc_q;
    redirect_d = 1'b0;
    tgt_chk    = 1'b0;
    if (bus.trap_i) begin
      npc        = TRAP_VEC;
      redirect_d = 1'b1;
    end else if (bus.br_taken_i) begin
      npc        = bus.br_target_i;
      redirect_d = 1'b1;
      tgt_chk    = 1'b1;
    end else if (bus.jmp_i) begin
      redirect_d = 1'b1;
      tgt_chk    = 1'b1;
      if (bus.ret_i && cnt_q != '0) npc = ras_top;
      else if (bus.ret_i)           npc = bus.ret_target_i;
      else                          npc = bus.jmp_target_i;
    end else if (bus.stall_i) begin
      npc = pc_q;
    end
  end

  assign misalign_d = tgt_chk & (|(npc & LOW_MASK));
  assign pc_d       = npc & ~LOW_MASK;

  // ptr_q always addresses the top entry; a push into a full stack lands
  // on the oldest slot because the pointer wraps.
  always_comb begin
    ras_en = bus.jmp_i & ~bus.trap_i & ~bus.br_taken_i;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (ras_en) begin
      if (bus.call_i && bus.ret_i) begin
        wr_en = 1'b1;
        if (cnt_q == '0) cnt_d = CW'(1);
      end else if (bus.call_i) begin
        wr_en  = 1'b1;
        ptr_d  = ptr_q + PW'(1);
        wr_idx = ptr_q + PW'(1);
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else if (bus.ret_i && cnt_q != '0) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= 1'b1;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      empty_q    <= (cnt_d == '0);
      full_q     <= (cnt_d == CNT_MAX);
    end
  end

  // Stack contents need no reset: a zero count makes every entry dead.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) ras_q[wr_idx] <= ret_addr;
  end

  assign bus.pc_o        = pc_q;
  assign bus.npc_o       = npc;
  assign bus.pc_valid_o  = valid_q;
  assign bus.redirect_o  = redirect_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.ras_empty_o = empty_q;
  assign bus.ras_full_o  = full_q;
endmodule
